// File: rtl/sdram_frame_sched.sv
// Ring-of-frames scheduler in front of the SDRAM FIFO/controller top: gates ADC writes, paces read prefetch, releases slots.
// Latency: wr_en and sdram_read_valid are registered (one cycle after the deciding inputs); rd_en is combinational.
// Backpressure: ADC words are dropped (counted, sticky overflow) when no slot is free or wrf_full is high; reads stall on rdf_empty.
//
// Ports:
//   clk, rst                      scheduler clock, synchronous active-high reset
//   sdram_init_done               SDRAM ready; starts the first load sequence
//   cap_en                        capture run request (level)
//   adc_valid, wrf_full -> wr_en  write-side gating into the write FIFO
//   usb_rd_en, rdf_empty -> rd_en read-side handshake from the USB side
//   wr/rd_min/max_addr            constant ring bounds
//   wr_load, rd_load              two-cycle pointer reset / FIFO clear pulse
//   sdram_read_valid              read prefetch enable, kept inside committed data
//   frame_avail, ready_frames     committed but unread frames
//   overflow, drop_cnt            sticky drop flag and saturating drop count
module sdram_frame_sched #(
    parameter int          FRAME_WORDS    = 4096,
    parameter int          NUM_FRAMES     = 4,
    parameter logic [23:0] BASE_ADDR      = 24'd0,
    parameter int          DRAIN_CYCLES   = 64,
    parameter int          PREFETCH_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdram_init_done,
    input  logic        cap_en,
    input  logic        adc_valid,
    input  logic        wrf_full,
    input  logic        usb_rd_en,
    input  logic        rdf_empty,
    output logic        wr_en,
    output logic [23:0] wr_min_addr,
    output logic [23:0] wr_max_addr,
    output logic [23:0] rd_min_addr,
    output logic [23:0] rd_max_addr,
    output logic        wr_load,
    output logic        rd_load,
    output logic        sdram_read_valid,
    output logic        rd_en,
    output logic        frame_avail,
    output logic [2:0]  ready_frames,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam int CW = $clog2(FRAME_WORDS);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    localparam logic [CW-1:0] LAST_WORD  = CW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] RD_LIMIT   = CW'(FRAME_WORDS - PREFETCH_WORDS);
    localparam logic [2:0]    NF         = 3'(NUM_FRAMES);
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
    localparam logic [23:0]   RING_END   = BASE_ADDR + 24'(FRAME_WORDS * NUM_FRAMES);

    typedef enum logic [2:0] {
        S_WAIT_INIT,
        S_LOAD,
        S_IDLE,
        S_RUN,
        S_STOP
    } state_t;

    state_t        state;
    logic          load_cnt;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] rcnt;
    logic [2:0]    used_frames;
    logic [DW-1:0] drain;

    logic accept;
    logic wr_wrap;
    logic rd_wrap;
    logic frame_start;
    logic drain_done;
    logic rd_window;

    assign wr_min_addr = BASE_ADDR;
    assign rd_min_addr = BASE_ADDR;
    assign wr_max_addr = RING_END;
    assign rd_max_addr = RING_END;

    // A new frame may only be opened when a slot is free; a frame already
    // open always runs to completion.
    assign accept      = (state == S_RUN) && adc_valid && !wrf_full &&
                         ((wcnt != '0) || (used_frames < NF));
    assign rd_en       = usb_rd_en & ~rdf_empty;
    assign wr_wrap     = accept && (wcnt == LAST_WORD);
    assign rd_wrap     = rd_en && (rcnt == LAST_WORD);
    assign frame_start = accept && (wcnt == '0);
    assign drain_done  = (drain == DW'(1));
    assign frame_avail = (ready_frames != 3'd0);

    // With a single committed frame, stop prefetching once the FIFO
    // read-ahead could run past its end into uncommitted data.
    assign rd_window = ((state == S_RUN) || (state == S_STOP)) &&
                       ((ready_frames >= 3'd2) ||
                        ((ready_frames == 3'd1) && (rcnt < RD_LIMIT)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_WAIT_INIT;
            load_cnt         <= 1'b0;
            wcnt             <= '0;
            rcnt             <= '0;
            used_frames      <= 3'd0;
            ready_frames     <= 3'd0;
            drain            <= '0;
            wr_en            <= 1'b0;
            wr_load          <= 1'b0;
            rd_load          <= 1'b0;
            sdram_read_valid <= 1'b0;
            overflow         <= 1'b0;
            drop_cnt         <= 16'd0;
        end else begin
            wr_en            <= accept;
            sdram_read_valid <= rd_window;

            if ((state == S_RUN) && adc_valid && !accept) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end

            if (state == S_LOAD) begin
                wcnt         <= '0;
                rcnt         <= '0;
                used_frames  <= 3'd0;
                ready_frames <= 3'd0;
                drain        <= '0;
            end else begin
                if (accept) begin
                    wcnt <= wr_wrap ? '0 : wcnt + CW'(1);
                end

                // FRAME_WORDS > DRAIN_CYCLES, so a reload never lands on a
                // timer that is still running.
                if (wr_wrap) begin
                    drain <= DRAIN_LOAD;
                end else if (drain != '0) begin
                    drain <= drain - DW'(1);
                end

                if (rd_en) begin
                    rcnt <= rd_wrap ? '0 : rcnt + CW'(1);
                end

                case ({drain_done, rd_wrap})
                    2'b10:   ready_frames <= ready_frames + 3'd1;
                    2'b01:   ready_frames <= ready_frames - 3'd1;
                    default: ;
                endcase

                case ({frame_start, rd_wrap})
                    2'b10:   used_frames <= used_frames + 3'd1;
                    2'b01:   used_frames <= used_frames - 3'd1;
                    default: ;
                endcase
            end

            case (state)
                S_WAIT_INIT: begin
                    if (sdram_init_done) begin
                        state    <= S_LOAD;
                        load_cnt <= 1'b0;
                        wr_load  <= 1'b1;
                        rd_load  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_cnt) begin
                        state   <= S_IDLE;
                        wr_load <= 1'b0;
                        rd_load <= 1'b0;
                    end else begin
                        load_cnt <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (cap_en) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!cap_en) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // Wait for the reader to empty the ring; any partial
                    // write frame is thrown away by the reload.
                    if ((ready_frames == 3'd0) && (drain == '0) && (rcnt == '0)) begin
                        state    <= S_LOAD;
                        load_cnt <= 1'b0;
                        wr_load  <= 1'b1;
                        rd_load  <= 1'b1;
                    end
                end
                default: state <= S_WAIT_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_frame_sched.sv
module tb_sdram_frame_sched;

    localparam int FW = 64;
    localparam int NF = 2;
    localparam int DR = 8;
    localparam int PF = 16;

    localparam int P_WAIT = 0;
    localparam int P_LOAD = 1;
    localparam int P_IDLE = 2;
    localparam int P_RUN  = 3;
    localparam int P_STOP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdram_init_done;
    logic        cap_en;
    logic        adc_valid;
    logic        wrf_full;
    logic        usb_rd_en;
    logic        rdf_empty;
    logic        wr_en;
    logic [23:0] wr_min_addr;
    logic [23:0] wr_max_addr;
    logic [23:0] rd_min_addr;
    logic [23:0] rd_max_addr;
    logic        wr_load;
    logic        rd_load;
    logic        sdram_read_valid;
    logic        rd_en;
    logic        frame_avail;
    logic [2:0]  ready_frames;
    logic        overflow;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    sdram_frame_sched #(
        .FRAME_WORDS   (FW),
        .NUM_FRAMES    (NF),
        .BASE_ADDR     (24'd0),
        .DRAIN_CYCLES  (DR),
        .PREFETCH_WORDS(PF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sdram_init_done (sdram_init_done),
        .cap_en          (cap_en),
        .adc_valid       (adc_valid),
        .wrf_full        (wrf_full),
        .usb_rd_en       (usb_rd_en),
        .rdf_empty       (rdf_empty),
        .wr_en           (wr_en),
        .wr_min_addr     (wr_min_addr),
        .wr_max_addr     (wr_max_addr),
        .rd_min_addr     (rd_min_addr),
        .rd_max_addr     (rd_max_addr),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .sdram_read_valid(sdram_read_valid),
        .rd_en           (rd_en),
        .frame_avail     (frame_avail),
        .ready_frames    (ready_frames),
        .overflow        (overflow),
        .drop_cnt        (drop_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: frame-level bookkeeping with integers and commit timestamps.
    int cyc         = 0;
    int m_phase     = P_WAIT;
    int m_load_left = 0;
    int m_wfill     = 0;   // words in the frame being written
    int m_used      = 0;   // frames holding any data
    int m_ready     = 0;   // committed, unread frames
    int m_rpos      = 0;   // words read from the current read frame
    int m_commit_at = -1;  // edge index at which the filled frame becomes committed
    int m_drops     = 0;
    int m_ovf       = 0;
    int m_wr_en     = 0;
    int m_srv       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int acc, rd, inc, dec, pending, stop_ok, srv_new;
        cyc++;
        acc = (m_phase == P_RUN && adc_valid && !wrf_full && (m_wfill != 0 || m_used < NF)) ? 1 : 0;
        rd  = (usb_rd_en && !rdf_empty) ? 1 : 0;
        if (rst) begin
            m_phase = P_WAIT; m_load_left = 0; m_wfill = 0; m_used = 0; m_ready = 0;
            m_rpos = 0; m_commit_at = -1; m_drops = 0; m_ovf = 0; m_wr_en = 0; m_srv = 0;
            return;
        end
        srv_new = ((m_phase == P_RUN || m_phase == P_STOP) &&
                   (m_ready >= 2 || (m_ready == 1 && m_rpos < FW - PF))) ? 1 : 0;
        m_wr_en = acc;
        if (m_phase == P_RUN && adc_valid && !acc) begin
            m_ovf = 1;
            if (m_drops < 65535) m_drops++;
        end
        pending = (m_commit_at >= cyc) ? 1 : 0;
        if (m_phase == P_LOAD) begin
            m_wfill = 0; m_used = 0; m_ready = 0; m_rpos = 0; m_commit_at = -1;
            m_load_left--;
            if (m_load_left == 0) m_phase = P_IDLE;
        end else begin
            stop_ok = (m_ready == 0 && !pending && m_rpos == 0) ? 1 : 0;
            inc = (m_commit_at == cyc) ? 1 : 0;
            if (inc) m_commit_at = -1;
            dec = (rd && m_rpos == FW - 1) ? 1 : 0;
            m_ready = m_ready + inc - dec;
            if (acc && m_wfill == 0) m_used++;
            if (dec) m_used--;
            if (rd) m_rpos = (m_rpos + 1) % FW;
            if (acc) begin
                m_wfill++;
                if (m_wfill == FW) begin
                    m_wfill = 0;
                    m_commit_at = cyc + DR;
                end
            end
            case (m_phase)
                P_WAIT: if (sdram_init_done) begin m_phase = P_LOAD; m_load_left = 2; end
                P_IDLE: if (cap_en) m_phase = P_RUN;
                P_RUN:  if (!cap_en) m_phase = P_STOP;
                P_STOP: if (stop_ok) begin m_phase = P_LOAD; m_load_left = 2; end
                default: ;
            endcase
        end
        m_srv = srv_new;
    endtask

    task automatic check_regs();
        chk("wr_en",            wr_en,            m_wr_en);
        chk("wr_load",          wr_load,          (m_phase == P_LOAD) ? 1 : 0);
        chk("rd_load",          rd_load,          (m_phase == P_LOAD) ? 1 : 0);
        chk("sdram_read_valid", sdram_read_valid, m_srv);
        chk("ready_frames",     ready_frames,     m_ready);
        chk("frame_avail",      frame_avail,      (m_ready != 0) ? 1 : 0);
        chk("used_frames",      dut.used_frames,  m_used);
        chk("overflow",         overflow,         m_ovf);
        chk("drop_cnt",         drop_cnt,         m_drops);
        chk("wr_min_addr",      wr_min_addr,      0);
        chk("rd_min_addr",      rd_min_addr,      0);
        chk("wr_max_addr",      wr_max_addr,      FW * NF);
        chk("rd_max_addr",      rd_max_addr,      FW * NF);
    endtask

    // One clock: combinational check before the edge, registered checks after it.
    task automatic step();
        #1;
        chk("rd_en", rd_en, (usb_rd_en && !rdf_empty) ? 1 : 0);
        @(posedge clk);
        model_step();
        #1;
        check_regs();
    endtask

    int n;

    initial begin
        rst = 1'b1; sdram_init_done = 1'b0; cap_en = 1'b0; adc_valid = 1'b0;
        wrf_full = 1'b0; usb_rd_en = 1'b0; rdf_empty = 1'b1;

        // 1: reset, init at cycle 10, two-cycle load pulse
        repeat (3) step();
        rst = 1'b0;
        repeat (6) step();
        sdram_init_done = 1'b1;
        n = 0;
        repeat (8) begin step(); n += int'(wr_load); end
        chk("load_pulse_len", n, 2);
        chk("idle_wr_en", wr_en, 0);

        // 2: one full frame, commit after the drain delay
        cap_en = 1'b1;
        step();
        adc_valid = 1'b1;
        n = 0;
        repeat (64) begin step(); n += int'(wr_en); end
        chk("frame1_accepts", n, 64);
        adc_valid = 1'b0;
        repeat (7) step();
        chk("ready_before_drain", ready_frames, 0);
        step();
        chk("ready_after_drain", ready_frames, 1);
        chk("srv_same_cycle", sdram_read_valid, 0);
        step();
        chk("srv_next_cycle", sdram_read_valid, 1);

        // 3: fill the ring, then drops
        adc_valid = 1'b1;
        n = 0;
        repeat (74) begin step(); n += int'(wr_en); end
        chk("frame2_accepts", n, 64);
        adc_valid = 1'b0;
        repeat (10) step();
        chk("ring_full_ready", ready_frames, 2);
        chk("ring_full_drops", drop_cnt, 10);
        chk("ring_full_ovf", overflow, 1);

        // 4: drain both frames through the reader
        usb_rd_en = 1'b1;
        n = 0;
        for (int i = 0; i < 140; i++) begin
            rdf_empty = (m_ready == 0);
            step();
            n += int'(dut.rcnt != 0 || rd_en);
        end
        usb_rd_en = 1'b0; rdf_empty = 1'b1;
        step();
        chk("read_all_ready", ready_frames, 0);
        chk("read_all_used", dut.used_frames, 0);
        chk("read_all_srv", sdram_read_valid, 0);

        // 5: write-FIFO full stalls five words
        adc_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 69; i++) begin
            wrf_full = (i >= 10 && i < 15);
            step();
            n += int'(wr_en);
        end
        wrf_full = 1'b0; adc_valid = 1'b0;
        chk("full_accepts", n, 64);
        chk("full_drops", drop_cnt, 15);
        repeat (12) step();
        chk("full_frame_ready", ready_frames, 1);

        // 6: commit and last read of the other frame on the same edge
        for (int i = 0; i < 80; i++) begin
            adc_valid = (i < 64);
            usb_rd_en = (i >= 8 && i < 72);
            rdf_empty = (m_ready == 0);
            step();
            if (i == 71) chk("coincide_ready", ready_frames, 1);
        end
        adc_valid = 1'b0;

        // stop: reader drains, reload pulse, back to idle
        cap_en = 1'b0;
        usb_rd_en = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            rdf_empty = (m_ready == 0);
            step();
            n += int'(wr_load);
        end
        usb_rd_en = 1'b0; rdf_empty = 1'b1;
        step();
        chk("stop_reload_len", n, 2);
        chk("stop_ready", ready_frames, 0);

        // randomized traffic with cap_en toggles, init_done glitches and a mid-run reset
        cap_en = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            adc_valid       = ($urandom % 4) != 0;
            wrf_full        = ($urandom % 8) == 0;
            usb_rd_en       = ($urandom % 2) != 0;
            rdf_empty       = (m_ready == 0) || (($urandom % 4) == 0);
            sdram_init_done = ($urandom % 8) != 0;
            if (($urandom % 300) == 0) cap_en = ~cap_en;
            rst             = (i >= 1200 && i < 1202);
            step();
        end
        rst = 1'b0;

        // final reset taken while running
        cap_en = 1'b1; sdram_init_done = 1'b1; usb_rd_en = 1'b0; rdf_empty = 1'b1;
        for (int i = 0; i < 500 && m_phase != P_RUN; i++) begin
            adc_valid = ($urandom % 2) != 0;
            step();
        end
        adc_valid = 1'b1;
        repeat (5) step();
        rst = 1'b1; adc_valid = 1'b0;
        step();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_load", wr_load, 0);
        chk("rst_srv", sdram_read_valid, 0);
        chk("rst_ready", ready_frames, 0);
        chk("rst_frame_avail", frame_avail, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_rd_en", rd_en, 0);
        rst = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_frame_sched.md
Name: sdram_frame_sched

Overview:
Frame-level scheduler in front of the SDRAM top (FIFO controller plus SDRAM controller) in the ADC-to-USB capture path. It treats a fixed SDRAM region as a ring of NUM_FRAMES frames and issues the region bounds and the load pulses. It gates ADC words into the write FIFO only when a frame slot is free. It gates sdram_read_valid so the read prefetch never passes committed data, and it releases slots as the USB side consumes them.

Parameters:
FRAME_WORDS, 4096, 16-bit words per frame; must be greater than DRAIN_CYCLES and PREFETCH_WORDS, and a multiple of the burst length.
NUM_FRAMES, 4, frames in the ring (2..7).
BASE_ADDR, 24'd0, first SDRAM word address of the ring.
DRAIN_CYCLES, 64, clk cycles after a frame's last accepted word before the frame counts as committed to SDRAM.
PREFETCH_WORDS, 512, read-FIFO depth plus rd_len; the maximum read-ahead of the FIFO controller.

Ports:
clk  in  1  scheduler clock; same clock as the SDRAM controller reference clock.
rst  in  1  synchronous reset, active-high.
sdram_init_done  in  1  SDRAM initialisation complete.
cap_en  in  1  level; capture run request.
adc_valid  in  1  ADC word present this cycle.
wrf_full  in  1  write FIFO full.
usb_rd_en  in  1  USB side requests a word.
rdf_empty  in  1  read FIFO empty.
wr_en  out  1  write-FIFO write enable (adc_valid accepted).
wr_min_addr  out  24  ring start address.
wr_max_addr  out  24  ring end address.
rd_min_addr  out  24  ring start address.
rd_max_addr  out  24  ring end address.
wr_load  out  1  write pointer reset and write-FIFO clear.
rd_load  out  1  read pointer reset and read-FIFO clear.
sdram_read_valid  out  1  read prefetch enable.
rd_en  out  1  read-FIFO read enable.
frame_avail  out  1  at least one committed, unread frame.
ready_frames  out  3  committed, unread frames.
overflow  out  1  sticky; at least one ADC word dropped.
drop_cnt  out  16  dropped ADC words, saturating at 16'hFFFF.

Behaviour:
- Address outputs are constant: min = BASE_ADDR, max = BASE_ADDR + FRAME_WORDS*NUM_FRAMES.
- Reset values: all other outputs 0; internal counters 0; FSM in WAIT_INIT.
- FSM states and transitions:
  - WAIT_INIT: on sdram_init_done=1, go to LOAD.
  - LOAD: wr_load=rd_load=1 for exactly 2 cycles. Clear wcnt, rcnt, used_frames, ready_frames and the drain timer. Then go to IDLE.
  - IDLE: on cap_en=1, go to RUN.
  - RUN: on cap_en=0, go to STOP.
  - STOP: no writes accepted. Reader continues. Go to LOAD when ready_frames=0, the drain timer is idle and rcnt=0. Any partial write frame is discarded by the wr_load clear.
- Write gating, registered (wr_en is high the cycle after the accepting condition):
  - Accept when state=RUN, adc_valid=1, wrf_full=0, and either wcnt≠0 or used_frames<NUM_FRAMES.
  - An accept with wcnt=0 increments used_frames.
  - Each accept increments wcnt. At FRAME_WORDS-1, wcnt wraps to 0 and the drain timer loads DRAIN_CYCLES.
  - adc_valid=1 while in RUN without acceptance: set overflow and increment drop_cnt (saturating).
- Drain timer:
  - Counts down to 0; on the 1→0 transition, ready_frames increments.
  - Only one frame drains at a time, which is guaranteed by FRAME_WORDS>DRAIN_CYCLES.
- Read side:
  - rd_en = usb_rd_en & !rdf_empty, combinational.
  - Each rd_en increments rcnt. At FRAME_WORDS-1, rcnt wraps to 0 and both ready_frames and used_frames decrement.
  - If ready_frames increment and decrement coincide, it holds its value.
- sdram_read_valid is registered. It is 1 when state is RUN or STOP and either:
  - ready_frames≥2, or
  - ready_frames=1 and rcnt < FRAME_WORDS-PREFETCH_WORDS.
  Otherwise it is 0, so the FIFO read-ahead stays inside committed data.
- frame_avail = (ready_frames≠0).
- sdram_init_done falling after WAIT_INIT is ignored. Only rst returns the FSM to WAIT_INIT.
- rst mid-operation: everything clears and a fresh LOAD follows the next sdram_init_done. overflow and drop_cnt clear only on rst.

Test Plan:
FRAME_WORDS=64, NUM_FRAMES=2, DRAIN_CYCLES=8, PREFETCH_WORDS=16 for all scenarios.
1. Assert rst, then init_done=1 at cycle 10 → wr_load and rd_load high for exactly 2 cycles; min=0, max=128; all other outputs 0 until cap_en.
2. cap_en=1 with 64 continuous adc_valid → 64 wr_en pulses; ready_frames goes 0→1 eight cycles after the last accept; sdram_read_valid=1 the next cycle.
3. Continuous adc_valid with no USB reads → 128 words accepted; words 129 onward dropped; overflow=1; drop_cnt counts each dropped cycle; ready_frames=2.
4. One frame ready, then usb_rd_en held high → sdram_read_valid drops the cycle after rcnt reaches 48; after 64 reads, ready_frames=0 and used_frames=0.
5. wrf_full=1 for 5 cycles during valid ADC data → 5 drops, wcnt frozen; acceptance resumes when wrf_full falls.
6. Frame commit and last read of a frame in the same cycle → ready_frames unchanged; then cap_en=0 → reader drains, 2-cycle load pulse, IDLE; rst mid-RUN → all outputs 0.
